dmem_load_store_unit: RTL and testbench

//  Bridges the execute stage to port B of the byte-write data BRAM.

---
 rtl/dmem_load_store_unit_if.sv | 40 ++++
 rtl/dmem_load_store_unit.sv | 178 +++++++++++++++++
 tb/tb_dmem_load_store_unit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_load_store_unit_if.sv
// Execute-stage request/response and BRAM port-B bundle for dmem_load_store_unit.
// resp_err exists only when MISALIGN_TRAP_EN is defined.
interface dmem_load_store_unit_if #(
  parameter int unsigned ADDR_WIDTH = 15
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
`ifdef MISALIGN_TRAP_EN
  logic                  resp_err;
`endif
  logic                  mem_en;
  logic [3:0]            mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_din;
  logic [31:0]           mem_dout;

  // Execute stage plus BRAM side
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
    input  req_ready, resp_valid, resp_rdata, mem_en, mem_we, mem_addr, mem_din
`ifdef MISALIGN_TRAP_EN
    , input resp_err
`endif
  );

  // Load/store unit side
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
    output req_ready, resp_valid, resp_rdata, mem_en, mem_we, mem_addr, mem_din
`ifdef MISALIGN_TRAP_EN
    , output resp_err
`endif
  );
endinterface

// File: rtl/dmem_load_store_unit.sv
// RV32I load/store unit driving port B of a byte-write BRAM (1-cycle read latency).
// Optional MISALIGN_TRAP_EN: misaligned/illegal requests skip the BRAM and answer with resp_err.
module dmem_load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst,
  dmem_load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DATA} state_t;

  state_t                  stateQ, stateD;
  logic                    readyQ, readyD;
  logic                    memEnQ, memEnD;
  logic [3:0]              memWeQ, memWeD;
  logic [ADDR_WIDTH-1:0]   memAddrQ, memAddrD;
  logic [DATA_WIDTH-1:0]   memDinQ, memDinD;
  logic                    respValidQ, respValidD;
  logic [DATA_WIDTH-1:0]   respRdataQ, respRdataD;
`ifdef MISALIGN_TRAP_EN
  logic                    respErrQ, respErrD;
`endif
  logic [2:0]              fn3Q, fn3D;
  logic [1:0]              offQ, offD;
  logic                    weQ, weD;
  logic                    badQ, badD;

  logic [1:0]              reqOff, reqEffOff;
  logic                    reqIllegal, reqMisal, reqNoAccess;
  logic [3:0]              reqMask;
  logic [DATA_WIDTH-1:0]   reqDin;
  logic [DATA_WIDTH-1:0]   shifted, loadData;

  // Upper byte-address bits wrap and are deliberately ignored
  logic unusedAddrBits;
  assign unusedAddrBits = ^bus.req_addr[31:ADDR_WIDTH+2];

  // Request decode: lane offset, byte enables, replicated store data
  always_comb begin : decode
    reqOff      = bus.req_addr[1:0];
    reqIllegal  = (bus.req_funct3 == 3'b011) ||
                  (bus.req_funct3[2] && bus.req_funct3[1]) ||
                  (bus.req_we && bus.req_funct3[2]);
    reqMisal    = ((bus.req_funct3[1:0] == 2'b01) && reqOff[0]) ||
                  ((bus.req_funct3[1:0] == 2'b10) && (reqOff != 2'b00));
`ifdef MISALIGN_TRAP_EN
    reqNoAccess = reqIllegal || reqMisal;
`else
    reqNoAccess = reqIllegal;
`endif
    reqEffOff   = reqOff;
    reqMask     = 4'b0001 << reqOff;
    reqDin      = {4{bus.req_wdata[7:0]}};
    case (bus.req_funct3[1:0])
      2'b01: begin
        reqEffOff = {reqOff[1], 1'b0};
        reqMask   = 4'b0011 << {reqOff[1], 1'b0};
        reqDin    = {2{bus.req_wdata[15:0]}};
      end
      2'b10: begin
        reqEffOff = 2'b00;
        reqMask   = 4'hF;
        reqDin    = bus.req_wdata;
      end
      default: ;
    endcase
  end

  // Lane extraction and sign/zero extension of BRAM read data
  always_comb begin : extract
    shifted  = bus.mem_dout >> {offQ, 3'b000};
    loadData = '0;
    case (fn3Q)
      3'b000:  loadData = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  loadData = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  loadData = shifted;
      3'b100:  loadData = {24'h0, shifted[7:0]};
      3'b101:  loadData = {16'h0, shifted[15:0]};
      default: loadData = '0;
    endcase
    if (weQ || badQ) loadData = '0;
  end

  // Next-state and next-output logic
  always_comb begin : fsm
    stateD     = stateQ;
    memEnD     = 1'b0;
    memWeD     = 4'h0;
    memAddrD   = memAddrQ;
    memDinD    = memDinQ;
    respValidD = 1'b0;
    respRdataD = respRdataQ;
`ifdef MISALIGN_TRAP_EN
    respErrD   = 1'b0;
`endif
    fn3D       = fn3Q;
    offD       = offQ;
    weD        = weQ;
    badD       = badQ;
    case (stateQ)
      IDLE: begin
        if (bus.req_valid) begin
          fn3D     = bus.req_funct3;
          offD     = reqEffOff;
          weD      = bus.req_we;
          badD     = reqNoAccess;
          memEnD   = !reqNoAccess;
          memWeD   = (bus.req_we && !reqNoAccess) ? reqMask : 4'h0;
          memAddrD = bus.req_addr[ADDR_WIDTH+1:2];
          memDinD  = reqDin;
          stateD   = ACCESS;
        end
      end
      ACCESS: stateD = DATA;
      DATA: begin
        respValidD = 1'b1;
        respRdataD = loadData;
`ifdef MISALIGN_TRAP_EN
        respErrD   = badQ;
`endif
        stateD     = IDLE;
      end
      default: stateD = IDLE;
    endcase
    readyD = (stateD == IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ     <= IDLE;
      readyQ     <= 1'b1;
      memEnQ     <= 1'b0;
      memWeQ     <= 4'h0;
      memAddrQ   <= '0;
      memDinQ    <= '0;
      respValidQ <= 1'b0;
      respRdataQ <= '0;
`ifdef MISALIGN_TRAP_EN
      respErrQ   <= 1'b0;
`endif
      fn3Q       <= 3'b000;
      offQ       <= 2'b00;
      weQ        <= 1'b0;
      badQ       <= 1'b0;
    end else begin
      stateQ     <= stateD;
      readyQ     <= readyD;
      memEnQ     <= memEnD;
      memWeQ     <= memWeD;
      memAddrQ   <= memAddrD;
      memDinQ    <= memDinD;
      respValidQ <= respValidD;
      respRdataQ <= respRdataD;
`ifdef MISALIGN_TRAP_EN
      respErrQ   <= respErrD;
`endif
      fn3Q       <= fn3D;
      offQ       <= offD;
      weQ        <= weD;
      badQ       <= badD;
    end
  end

  assign bus.req_ready  = readyQ;
  assign bus.mem_en     = memEnQ;
  assign bus.mem_we     = memWeQ;
  assign bus.mem_addr   = memAddrQ;
  assign bus.mem_din    = memDinQ;
  assign bus.resp_valid = respValidQ;
  assign bus.resp_rdata = respRdataQ;
`ifdef MISALIGN_TRAP_EN
  assign bus.resp_err   = respErrQ;
`endif

endmodule

// File: tb/tb_dmem_load_store_unit.sv
// Directed bench for dmem_load_store_unit with a read-first byte-write BRAM model.
module tb_dmem_load_store_unit;
  localparam int unsigned AW = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_load_store_unit_if #(.ADDR_WIDTH(AW)) bus ();

  dmem_load_store_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // BRAM model: read-first, one-cycle latency, byte write enables
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      bus.mem_dout <= ram[bus.mem_addr[7:0]];
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) ram[bus.mem_addr[7:0]][b*8 +: 8] <= bus.mem_din[b*8 +: 8];
    end
  end

  int nChecks = 0;
  int nFails  = 0;

  logic        aReady, aEn, early, seenEn, rValid, rErr;
  logic [3:0]  aWe;
  logic [AW-1:0] aAddr;
  logic [31:0] aDin, rRdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
  endtask

  // One request: capture ACCESS-cycle BRAM signals and the response 3 edges later
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd);
    setReq(we, f3, addr, wd);
    bus.req_valid = 1'b1;
    aReady = bus.req_ready;
    tick;
    bus.req_valid = 1'b0;
    aEn = bus.mem_en; aWe = bus.mem_we; aAddr = bus.mem_addr; aDin = bus.mem_din;
    early = bus.resp_valid; seenEn = bus.mem_en;
    tick;
    early = early | bus.resp_valid; seenEn = seenEn | bus.mem_en;
    tick;
    rValid = bus.resp_valid; rRdata = bus.resp_rdata;
`ifdef MISALIGN_TRAP_EN
    rErr = bus.resp_err;
`else
    rErr = 1'b0;
`endif
  endtask

  logic [31:0] bbAddr [4] = '{32'h10, 32'h20, 32'h13, 32'h22};
  logic [2:0]  bbF3   [4] = '{3'b010, 3'b010, 3'b100, 3'b101};
  logic [31:0] bbExp  [4] = '{32'hA5ADBEEF, 32'h80015678, 32'h000000A5, 32'h00008001};
  logic [31:0] bbGot  [4];
  int          bbAcc  [4];
  int          nResp, idx;
  logic        acc, lateValid;

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0;
    setReq(1'b0, 3'b000, 32'h0, 32'h0);
    tick; tick;
    chk("rst_ready", 32'(bus.req_ready), 32'h1);
    chk("rst_mem_en", 32'(bus.mem_en), 32'h0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst_mem_din", bus.mem_din, 32'h0);
    chk("rst_rdata", bus.resp_rdata, 32'h0);
    rst = 1'b0;
    tick;

    // SW then LW
    xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    chk("sw_ready", 32'(aReady), 32'h1);
    chk("sw_en", 32'(aEn), 32'h1);
    chk("sw_addr", 32'(aAddr), 32'h4);
    chk("sw_we", 32'(aWe), 32'hF);
    chk("sw_din", aDin, 32'hDEADBEEF);
    chk("sw_early", 32'(early), 32'h0);
    chk("sw_valid", 32'(rValid), 32'h1);
    chk("sw_rdata", rRdata, 32'h0);
    chk("sw_err", 32'(rErr), 32'h0);
    xact(1'b0, 3'b010, 32'h10, 32'h0);
    chk("lw_we", 32'(aWe), 32'h0);
    chk("lw_valid", 32'(rValid), 32'h1);
    chk("lw_rdata", rRdata, 32'hDEADBEEF);

    // SB to top lane, LB / LBU
    xact(1'b1, 3'b000, 32'h13, 32'h000000A5);
    chk("sb_we", 32'(aWe), 32'h8);
    chk("sb_din", aDin, 32'hA5A5A5A5);
    xact(1'b0, 3'b000, 32'h13, 32'h0);
    chk("lb_rdata", rRdata, 32'hFFFFFFA5);
    xact(1'b0, 3'b100, 32'h13, 32'h0);
    chk("lbu_rdata", rRdata, 32'h000000A5);

    // SH to upper half, LH / LHU, lower half preserved
    xact(1'b1, 3'b010, 32'h20, 32'h12345678);
    xact(1'b1, 3'b001, 32'h22, 32'h00008001);
    chk("sh_we", 32'(aWe), 32'hC);
    chk("sh_din", aDin, 32'h80018001);
    xact(1'b0, 3'b001, 32'h22, 32'h0);
    chk("lh_rdata", rRdata, 32'hFFFF8001);
    xact(1'b0, 3'b101, 32'h22, 32'h0);
    chk("lhu_rdata", rRdata, 32'h00008001);
    xact(1'b0, 3'b010, 32'h20, 32'h0);
    chk("sh_word", rRdata, 32'h80015678);

    // Upper address bits wrap
    xact(1'b0, 3'b010, 32'h00020010, 32'h0);
    chk("wrap_addr", 32'(aAddr), 32'h4);
    chk("wrap_rdata", rRdata, 32'hA5ADBEEF);

    // Illegal load funct3 and illegal store funct3
    xact(1'b0, 3'b011, 32'h10, 32'h0);
    chk("ill_ld_en", 32'(seenEn), 32'h0);
    chk("ill_ld_valid", 32'(rValid), 32'h1);
    chk("ill_ld_rdata", rRdata, 32'h0);
    xact(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF);
    chk("ill_st_en", 32'(seenEn), 32'h0);
    chk("ill_st_we", 32'(aWe), 32'h0);
    chk("ill_st_valid", 32'(rValid), 32'h1);
`ifdef MISALIGN_TRAP_EN
    chk("ill_st_err", 32'(rErr), 32'h1);
`endif
    xact(1'b0, 3'b010, 32'h10, 32'h0);
    chk("ill_st_nowrite", rRdata, 32'hA5ADBEEF);

    // Misaligned accesses
    xact(1'b0, 3'b010, 32'h11, 32'h0);
    chk("mis_lw_valid", 32'(rValid), 32'h1);
`ifdef MISALIGN_TRAP_EN
    chk("mis_lw_en", 32'(seenEn), 32'h0);
    chk("mis_lw_err", 32'(rErr), 32'h1);
    chk("mis_lw_rdata", rRdata, 32'h0);
`else
    chk("mis_lw_rdata", rRdata, 32'hA5ADBEEF);
`endif
    xact(1'b0, 3'b001, 32'h23, 32'h0);
`ifdef MISALIGN_TRAP_EN
    chk("mis_lh_err", 32'(rErr), 32'h1);
    chk("mis_lh_rdata", rRdata, 32'h0);
`else
    chk("mis_lh_rdata", rRdata, 32'hFFFF8001);
`endif

    // Back-to-back loads with req_valid held high
    nResp = 0; idx = 0;
    setReq(1'b0, bbF3[0], bbAddr[0], 32'h0);
    bus.req_valid = 1'b1;
    for (int c = 0; c < 30 && nResp < 4; c++) begin
      acc = bus.req_ready && bus.req_valid;
      tick;
      if (acc) begin
        bbAcc[idx] = c;
        idx++;
        if (idx < 4) setReq(1'b0, bbF3[idx], bbAddr[idx], 32'h0);
        else bus.req_valid = 1'b0;
      end
      if (bus.resp_valid) begin
        bbGot[nResp] = bus.resp_rdata;
        nResp++;
      end
    end
    bus.req_valid = 1'b0;
    chk("bb_nresp", 32'(nResp), 32'd4);
    chk("bb_naccept", 32'(idx), 32'd4);
    if (nResp == 4 && idx == 4) begin
      for (int i = 1; i < 4; i++) chk("bb_spacing", 32'(bbAcc[i] - bbAcc[i-1]), 32'd3);
      for (int i = 0; i < 4; i++) chk("bb_rdata", bbGot[i], bbExp[i]);
    end

    // Reset during DATA of a LW
    setReq(1'b0, 3'b010, 32'h10, 32'h0);
    bus.req_valid = 1'b1;
    tick;
    bus.req_valid = 1'b0;
    chk("abort_busy", 32'(bus.req_ready), 32'h0);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_valid", 32'(bus.resp_valid), 32'h0);
    chk("abort_ready", 32'(bus.req_ready), 32'h1);
    chk("abort_en", 32'(bus.mem_en), 32'h0);
    chk("abort_we", 32'(bus.mem_we), 32'h0);
    chk("abort_addr", 32'(bus.mem_addr), 32'h0);
    chk("abort_din", bus.mem_din, 32'h0);
    chk("abort_rdata", bus.resp_rdata, 32'h0);
    lateValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      lateValid = lateValid | bus.resp_valid;
    end
    chk("abort_no_resp", 32'(lateValid), 32'h0);
    xact(1'b0, 3'b010, 32'h10, 32'h0);
    chk("post_abort_valid", 32'(rValid), 32'h1);
    chk("post_abort_rdata", rRdata, 32'hA5ADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
